vga_pxl_write_ctrl: RTL
=======================

// Module: vga_pxl_write_ctrl
// PURPOSE
//  Avalon-MM slave between the Nios and the VGA frame buffer write port.
//  Software queues pixel writes as (x, y, colour) commands; the block buffers them in a small FIFO.
//  It computes the linear frame-buffer address and writes each pixel when the scanout reader leaves the port free.
//  Scanout always has priority. This replaces direct per-pixel PIO bit-banging.
// PARAMETERS
//  H_RES       640  active pixels per line; addr = y*H_RES + x
//  V_RES       480  active lines
//  ADDR_W      19   frame buffer address width
//  COLOR_W     4    pixel colour width
//  FIFO_DEPTH  4    command FIFO entries (power of 2)
// PORTS
//  clk         in   1        system clock; the only clock
//  reset       in   1        synchronous, active-high reset
//  address     in   2        register select
//  chipselect  in   1        slave select
//  write_n     in   1        active-low write strobe
//  writedata   in   32       write data
//  readdata    out  32       read data, combinational from address
//  scan_req    in   1        scanout uses the frame-buffer port this cycle
//  fb_we       out  1        frame buffer write enable
//  fb_addr     out  ADDR_W   frame buffer write address
//  fb_wdata    out  COLOR_W  frame buffer write data
//  busy        out  1        (state!=IDLE) | FIFO non-empty
// BEHAVIOUR
//  Write = chipselect & ~write_n. Unused readdata bits are 0.
//  Registers:
//   0 XY:
//    - write latches x=wd[9:0], y=wd[25:16]; reads back the same layout.
//   1 CMD:
//    - write pushes {x,y,wd[COLOR_W-1:0]}.
//    - reads {COLOR_W of last pushed colour}.
//   2 STATUS (read):
//    - [2:0] FIFO level, [3] full, [4] busy, [5] overflow, [6] range_err.
//    - write 1 to bit 5 or bit 6 clears it.
//   3 CTRL:
//    - [0] enable, reset value 1. Reads back.
//  Push rules:
//   - Full is judged on the level before any same-cycle pop.
//   - CMD write when full: dropped, overflow<=1.
//   - CMD write with x>=H_RES or y>=V_RES: dropped, range_err<=1. Range check takes precedence over full.
//   - A sticky set and a W1C in the same cycle: the set wins.
//   - Push and pop in the same cycle are both legal; level unchanged.
//  FSM IDLE -> LOAD -> ARB:
//   - IDLE: if enable & ~empty -> LOAD.
//   - LOAD: pop head; register fb_addr = y*H_RES + x and fb_wdata = colour -> ARB.
//   - ARB: fb_we = ~scan_req (combinational). If ~scan_req -> IDLE, else stay in ARB.
//   - fb_addr and fb_wdata stay stable throughout ARB.
//  Timing:
//   - Latency: a CMD write at edge N gives fb_we high in cycle N+3 if scan_req is low; 3 cycles per pixel sustained.
//   - scan_req high stalls ARB indefinitely without losing the command.
//  Enable:
//   - enable=0 only blocks IDLE->LOAD.
//   - A command already in LOAD or ARB completes.
//  Reset:
//   - Applied at any time: FIFO emptied (pending commands discarded), state=IDLE.
//   - fb_we=0 in the cycle after the reset edge; fb_addr=0, fb_wdata=0.
//   - x=y=0, overflow=range_err=0, enable=1, busy=0.
//  Arithmetic:
//   - y*H_RES+x is computed unsigned at ADDR_W bits.
//   - Wrap-around is impossible because in-range commands satisfy < H_RES*V_RES <= 2^ADDR_W.
// STRUCTURE
//  Package vga_pkg holds:
//   - H_RES and V_RES defaults
//   - register offsets (REG_XY=0, REG_CMD=1, REG_STAT=2, REG_CTRL=3)
//   - STATUS bit positions
//   - state encoding (IDLE, LOAD, ARB)
//  Sub-module vga_cmd_fifo:
//   - synchronous FIFO with push, pop, full, empty, level and sync reset.
//  Top holds the register file, FSM and address multiply.
// TESTING
//  1 Reset values:
//   - After reset, read STAT=0x0 and CTRL=0x1.
//   - fb_we=0, busy=0.
//  2 Single pixel:
//   - XY x=5,y=2, then CMD colour 0xA, scan_req=0.
//   - Expect fb_we for exactly 1 cycle, 3 cycles after the CMD write, with fb_addr=1285 and fb_wdata=0xA.
//  3 Arbitration:
//   - Hold scan_req=1 for 10 cycles during ARB.
//   - fb_we stays 0, fb_addr is stable, and the write happens in the first cycle scan_req=0.
//  4 Overflow:
//   - enable=0, then 5 CMD writes.
//   - level=4, full=1, overflow=1.
//   - Write 0x20 to STAT: overflow=0.
//   - enable=1: exactly 4 writes, in order.
//  5 Range:
//   - CMD with x=640,y=0: no push, range_err=1, level unchanged.
//   - CMD with x=639,y=479: fb_addr=307199.
//  6 Reset mid-operation:
//   - Assert reset while in ARB with 3 queued commands.
//   - No fb_we after reset; level=0; busy=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel write controller: resolution defaults,
// register map, STATUS bit positions and FSM state encoding.
package vga_pkg;

  localparam int H_RES_DEF      = 640;
  localparam int V_RES_DEF      = 480;
  localparam int ADDR_W_DEF     = 19;
  localparam int COLOR_W_DEF    = 4;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] REG_XY   = 2'd0;
  localparam logic [1:0] REG_CMD  = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int STAT_FULL  = 3;
  localparam int STAT_BUSY  = 4;
  localparam int STAT_OVF   = 5;
  localparam int STAT_RANGE = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ARB  = 2'd2;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_pxl_write_ctrl_if.sv
// Avalon-MM slave bus plus frame-buffer write port of the pixel write controller.
// The slave modport is the controller's view; master is the Nios/scanout side.
interface vga_pxl_write_ctrl_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 4
);
  logic [1:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic               scan_req;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               busy;

  modport slave (
    input  address, chipselect, write_n, writedata, scan_req,
    output readdata, fb_we, fb_addr, fb_wdata, busy
  );

  modport master (
    output address, chipselect, write_n, writedata, scan_req,
    input  readdata, fb_we, fb_addr, fb_wdata, busy
  );
endinterface

// File: rtl/vga_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy level; head is read combinationally.
// Caller must not push when full nor pop when empty.
module vga_cmd_fifo #(
  parameter  int W     = 24,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/vga_pxl_write_ctrl.sv
// Queues (x, y, colour) pixel commands from the Nios and writes them into the
// frame buffer whenever scanout leaves the port free; scanout always wins.
module vga_pxl_write_ctrl
  import vga_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int COLOR_W    = COLOR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_pxl_write_ctrl_if.slave   bus
);

  localparam int CMD_W = 20 + COLOR_W;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam coord_t            H_LIM   = coord_t'(H_RES);
  localparam coord_t            V_LIM   = coord_t'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  logic               r_en, r_ovf, r_range;
  coord_t             r_x, r_y;
  logic [COLOR_W-1:0] r_last_color;
  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_fb_addr;
  logic [COLOR_W-1:0] r_fb_wdata;

  logic               w_wr, w_cmd_wr, w_range_bad, w_push, w_pop;
  logic               w_full, w_empty;
  logic [LW-1:0]      w_level;
  logic [CMD_W-1:0]   w_head;
  coord_t             w_head_x, w_head_y;
  logic [ADDR_W-1:0]  w_addr;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_cmd_wr    = w_wr & (bus.address == REG_CMD);
  assign w_range_bad = (r_x >= H_LIM) | (r_y >= V_LIM);
  // full is the registered level, so a same-cycle pop never frees a slot
  assign w_push      = w_cmd_wr & ~w_range_bad & ~w_full;
  assign w_pop       = (r_state == ST_LOAD);

  vga_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_dat   ({r_x, r_y, bus.writedata[COLOR_W-1:0]}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_head_x = w_head[CMD_W-1 -: 10];
  assign w_head_y = w_head[COLOR_W +: 10];
  assign w_addr   = ADDR_W'(w_head_y) * H_RES_A + ADDR_W'(w_head_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_en         <= 1'b1;
      r_ovf        <= 1'b0;
      r_range      <= 1'b0;
      r_last_color <= '0;
    end else begin
      if (w_wr && bus.address == REG_XY) begin
        r_x <= bus.writedata[9:0];
        r_y <= bus.writedata[25:16];
      end
      if (w_wr && bus.address == REG_CTRL) r_en <= bus.writedata[0];
      if (w_push) r_last_color <= bus.writedata[COLOR_W-1:0];
      // a sticky set beats a same-cycle write-one-to-clear
      if (w_cmd_wr && !w_range_bad && w_full)
        r_ovf <= 1'b1;
      else if (w_wr && bus.address == REG_STAT && bus.writedata[STAT_OVF])
        r_ovf <= 1'b0;
      if (w_cmd_wr && w_range_bad)
        r_range <= 1'b1;
      else if (w_wr && bus.address == REG_STAT && bus.writedata[STAT_RANGE])
        r_range <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fb_addr  <= '0;
      r_fb_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (r_en && !w_empty) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_fb_addr  <= w_addr;
          r_fb_wdata <= w_head[COLOR_W-1:0];
          r_state    <= ST_ARB;
        end
        ST_ARB:  if (!bus.scan_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      REG_XY: begin
        w_rdata[9:0]   = r_x;
        w_rdata[25:16] = r_y;
      end
      REG_CMD:  w_rdata[COLOR_W-1:0] = r_last_color;
      REG_STAT: begin
        w_rdata[2:0]        = 3'(w_level);
        w_rdata[STAT_FULL]  = w_full;
        w_rdata[STAT_BUSY]  = bus.busy;
        w_rdata[STAT_OVF]   = r_ovf;
        w_rdata[STAT_RANGE] = r_range;
      end
      REG_CTRL: w_rdata[0] = r_en;
      default:  w_rdata = '0;
    endcase
  end

  assign bus.readdata = w_rdata;
  assign bus.fb_we    = (r_state == ST_ARB) & ~bus.scan_req;
  assign bus.fb_addr  = r_fb_addr;
  assign bus.fb_wdata = r_fb_wdata;
  assign bus.busy     = (r_state != ST_IDLE) | ~w_empty;
  assign w_unused     = &{1'b0, bus.writedata[31:26], bus.writedata[15:10]};

endmodule
